// File: rtl/bus_slave_mem.sv
// Memory-backed bus slave: address-window match, programmable busy wait, single-word read/write.
// Optional macro BUS_SLAVE_MEM_ALIGN_CHK_EN refuses to acknowledge addresses not aligned to a word.
module bus_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rreq,
  input  logic        bus_wreq,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_busy
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic [31:0]            wdat_q, wdat_d;
  logic                   wr_q, wr_d;

  logic [31:0]            mem [DEPTH];
  logic                   mem_we;
  logic [DEPTH_LOG2-1:0]  mem_idx;
  logic [31:0]            mem_wdat;

  logic                   req_any;
  logic                   addr_match;

  assign req_any = bus_rreq | bus_wreq;

`ifdef BUS_SLAVE_MEM_ALIGN_CHK_EN
  assign addr_match = ((bus_addr & ADDR_MASK) == BASE_ADDR) && (bus_addr[1:0] == 2'b00);
`else
  assign addr_match = ((bus_addr & ADDR_MASK) == BASE_ADDR);
`endif

  assign bus_ack   = req_any & addr_match;
  assign bus_busy  = busy_q;
  assign bus_rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    rdata_d  = rdata_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    wr_d     = wr_q;
    mem_we   = 1'b0;
    mem_idx  = idx_q;
    mem_wdat = wdat_q;

    case (state_q)
      IDLE: begin
        if (bus_ack) begin
          idx_d  = bus_addr[DEPTH_LOG2+1:2];
          wdat_d = bus_wdata;
          wr_d   = bus_wreq;
          if (WAIT_CYCLES > 0) begin
            cnt_d   = CNT_INIT;
            busy_d  = 1'b1;
            state_d = WAIT;
          end else begin
            // Zero-wait: the access uses the live bus values on the accepting edge.
            mem_idx  = bus_addr[DEPTH_LOG2+1:2];
            mem_wdat = bus_wdata;
            mem_we   = bus_wreq;
            if (!bus_wreq) begin
              rdata_d = mem[bus_addr[DEPTH_LOG2+1:2]];
            end
            state_d = DONE;
          end
        end
      end

      WAIT: begin
        if (!req_any) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          mem_we = wr_q;
          if (!wr_q) begin
            rdata_d = mem[idx_q];
          end
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      DONE: begin
        // A still-held request is the tail of the finished access, not a new one.
        if (!req_any) begin
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0;
      idx_q   <= '0;
      wdat_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
    end
  end

  // Storage is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_idx] <= mem_wdat;
    end
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: vector table with read-data scoreboard, plus abort/reset/hold sequences.
module tb_bus_slave_mem;

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RW = 2'b11;

`ifdef BUS_SLAVE_MEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata;
  logic        rreq = 1'b0, wreq = 1'b0, ack, busy;

  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0, z_rdata;
  logic        z_rreq = 1'b0, z_wreq = 1'b0, z_ack, z_busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  bus_slave_mem #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_wdata(wdata),
    .bus_rreq(rreq), .bus_wreq(wreq), .bus_rdata(rdata), .bus_ack(ack), .bus_busy(busy)
  );

  bus_slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus_addr(z_addr), .bus_wdata(z_wdata),
    .bus_rreq(z_rreq), .bus_wreq(z_wreq), .bus_rdata(z_rdata), .bus_ack(z_ack), .bus_busy(z_busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on the WAIT_CYCLES=2 instance; busy must last exactly two cycles when acked.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_ack, input logic [31:0] exp_rd);
    int          nbusy;
    bit          fell;
    logic [31:0] e;
    rreq  = op[0];
    wreq  = op[1];
    addr  = a;
    wdata = d;
    #1;
    chk("ack", {31'b0, ack}, {31'b0, exp_ack});
    if (exp_ack && !op[1]) sb_q.push_back(exp_rd);
    nbusy = 0;
    fell  = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      tick();
      if (busy) nbusy++;
      else fell = 1'b1;
    end
    chk("busy_fell", {31'b0, busy}, 32'h0);
    chk("busy_cycles", 32'(nbusy), exp_ack ? 32'd2 : 32'd0);
    if (exp_ack && !op[1]) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0 + sb_q.size());
      end else begin
        e = sb_q.pop_front();
        chk("rdata", rdata, e);
        last_rd = e;
      end
    end
    rreq = 1'b0;
    wreq = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{OP_WR, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{OP_RD, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{OP_WR, 32'h0000_0004, 32'h1111_1111, 1'b1, 32'h0};
    vecs[3]  = '{OP_WR, 32'h0000_1004, 32'hBADB_AD00, 1'b0, 32'h0};
    vecs[4]  = '{OP_RD, 32'h0000_1004, 32'h0,         1'b0, 32'h0};
    vecs[5]  = '{OP_RD, 32'h0000_0004, 32'h0,         1'b1, 32'h1111_1111};
    vecs[6]  = '{OP_RW, 32'h0000_0008, 32'h1234_5678, 1'b1, 32'h0};
    vecs[7]  = '{OP_RD, 32'h0000_0008, 32'h0,         1'b1, 32'h1234_5678};
    vecs[8]  = '{OP_WR, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b1, 32'h0};
    vecs[9]  = '{OP_RD, 32'h0000_0FFC, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[10] = '{OP_WR, 32'h0000_0000, 32'h0000_0055, 1'b1, 32'h0};
    vecs[11] = '{OP_RD, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0055};
    vecs[12] = '{OP_RD, 32'h0000_0006, 32'h0,         !ALIGN_CHK, 32'h1111_1111};
    vecs[13] = '{OP_WR, 32'hFFFF_F000, 32'h0BAD_0BAD, 1'b0, 32'h0};
    vecs[14] = '{OP_RD, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0055};

    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy0", {31'b0, z_busy}, 32'h0);
    chk("rst_rdata0", z_rdata, 32'h0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_ack, vecs[i].exp_rd);

    // Read dropped in the first wait cycle: busy clears, rdata untouched, slave back in IDLE.
    rreq = 1'b1; addr = 32'h0000_0004;
    tick();
    chk("abort_busy_on", {31'b0, busy}, 32'h1);
    rreq = 1'b0;
    tick();
    chk("abort_busy_off", {31'b0, busy}, 32'h0);
    chk("abort_rdata", rdata, last_rd);
    run_txn(OP_RD, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // Write dropped on the final wait cycle must not reach memory.
    wreq = 1'b1; addr = 32'h0000_0000; wdata = 32'h0000_0088;
    tick();
    tick();
    chk("abort2_busy_on", {31'b0, busy}, 32'h1);
    wreq = 1'b0;
    tick();
    chk("abort2_busy_off", {31'b0, busy}, 32'h0);
    run_txn(OP_RD, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0055);

    // Address/data changes after acceptance are ignored.
    wreq = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_0001;
    tick();
    addr = 32'h0000_0024; wdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("late_chg_busy", {31'b0, busy}, 32'h0);
    wreq = 1'b0;
    tick();
    run_txn(OP_RD, 32'h0000_0020, 32'h0, 1'b1, 32'hCAFE_0001);

    // Zero-wait instance: held write and held read each cause exactly one access.
    z_wreq = 1'b1; z_addr = 32'h0000_0004; z_wdata = 32'h0000_00A1;
    #1;
    chk("z_ack", {31'b0, z_ack}, 32'h1);
    tick();
    chk("z_wr_busy1", {31'b0, z_busy}, 32'h0);
    z_wdata = 32'h0000_00B2;
    tick();
    chk("z_wr_busy2", {31'b0, z_busy}, 32'h0);
    tick();
    chk("z_wr_busy3", {31'b0, z_busy}, 32'h0);
    z_wreq = 1'b0;
    tick();
    z_rreq = 1'b1;
    tick();
    chk("z_rd_busy", {31'b0, z_busy}, 32'h0);
    chk("z_rd_data", z_rdata, 32'h0000_00A1);
    tick();
    tick();
    chk("z_rd_hold", z_rdata, 32'h0000_00A1);
    chk("z_rd_busy3", {31'b0, z_busy}, 32'h0);
    z_rreq = 1'b0;
    tick();

    // Reset in the middle of a wait discards the pending write.
    run_txn(OP_WR, 32'h0000_0030, 32'h0000_0001, 1'b1, 32'h0);
    wreq = 1'b1; addr = 32'h0000_0030; wdata = 32'h0000_0002;
    tick();
    chk("rst_mid_busy_on", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    reset = 1'b0;
    wreq = 1'b0;
    tick();
    run_txn(OP_RD, 32'h0000_0030, 32'h0, 1'b1, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: slave match base address.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFFF_F000: address bits compared against BASE_ADDR.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: memory holds 2^DEPTH_LOG2 32-bit words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..255: busy cycles per access.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port bus_addr  input  32  byte address from bus controller.
REQ-008 SHALL have port bus_wdata  input  32  write data.
REQ-009 SHALL have port bus_rreq  input  1  read request, level, held until completion seen.
REQ-010 SHALL have port bus_wreq  input  1  write request, level.
REQ-011 SHALL have port bus_rdata  output  32  registered read data.
REQ-012 SHALL have port bus_ack  output  1  address-match acknowledge, combinational.
REQ-013 SHALL have port bus_busy  output  1  access in progress, registered.

Function
REQ-014 SHALL drive bus_ack = (bus_rreq | bus_wreq) & ((bus_addr & ADDR_MASK) == BASE_ADDR), zero-latency, in every state.
REQ-015 SHALL index memory with bus_addr[DEPTH_LOG2+1:2]; bits above are ignored beyond the REQ-014 match.
REQ-016 SHALL implement states IDLE, WAIT, DONE.
REQ-017 IDLE: when bus_ack is 1, latch address, wdata and op (write if bus_wreq, else read). Write wins if both requests are high. If WAIT_CYCLES>0: load counter = WAIT_CYCLES-1, set bus_busy=1, go WAIT. If WAIT_CYCLES=0: perform access this edge, go DONE.
REQ-018 WAIT: bus_busy stays 1. Counter decrements each cycle. At counter==0 perform the latched access on that edge, clear bus_busy, go DONE. Busy is therefore high for exactly WAIT_CYCLES cycles.
REQ-019 Access: a read loads bus_rdata from mem[latched index]; a write stores the latched wdata and leaves bus_rdata unchanged.
REQ-020 WAIT abort: if bus_rreq and bus_wreq are both 0 in any WAIT cycle, SHALL discard the access (no memory write, bus_rdata unchanged), clear bus_busy on the next edge and go IDLE.
REQ-021 DONE: bus_busy=0 and bus_rdata is held. SHALL go IDLE on the first cycle with bus_rreq=0 and bus_wreq=0; a held request SHALL NOT start a second access.
REQ-022 Address or data changes after acceptance SHALL be ignored; the latched values are used.
REQ-023 Counter width SHALL be 8 bits; no wrap-around is permitted.

Reset
REQ-024 On reset: state=IDLE, bus_busy=0, bus_rdata=32'h0, counter=0, latches=0. Memory contents are not reset.
REQ-025 Reset asserted mid-WAIT SHALL abort the access with no memory write.

Configuration
REQ-026 Macro BUS_SLAVE_MEM_ALIGN_CHK_EN defined: REQ-014 additionally requires bus_addr[1:0]==2'b00, so an unaligned access gets no ack and no access starts (the controller faults with no-slave-response). Undefined: bus_addr[1:0] is ignored.

Verification
REQ-027 WAIT_CYCLES=2, write 0x0000_0010 data 0xDEADBEEF -> ack same cycle, busy high exactly 2 cycles, then read 0x10 returns 0xDEADBEEF after busy falls.
REQ-028 bus_addr=0x0000_1004 with default BASE/MASK -> bus_ack=0, busy never asserts, memory unchanged.
REQ-029 bus_rreq dropped in the 1st WAIT cycle -> busy clears next edge, bus_rdata retains previous value, state IDLE.
REQ-030 bus_rreq and bus_wreq both high, addr 0x8, data 0x12345678 -> write performed; a later read of 0x8 returns 0x12345678.
REQ-031 WAIT_CYCLES=0, read 0x4 -> busy stays 0, bus_rdata valid the cycle after acceptance; a request held 3 cycles causes exactly one access.
REQ-032 With BUS_SLAVE_MEM_ALIGN_CHK_EN defined, read 0x0000_0006 -> bus_ack=0; without it -> ack=1 and word 1 is returned.
